// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: central freeze/flush control for the 5-stage ARM pipeline.
// Combines RAW data hazards, taken branches and a multi-cycle memory wait
// handshake into per-register freeze/flush strobes, and keeps saturating
// stall/flush event counters for performance debug.
// Optional build macro HAZARD_FWD_EN: when defined, an EXE/MEM forwarding
// unit is assumed, so only load-use hazards stall the front end.
module hazard_ctrl_unit #(
    parameter int REG_AW       = 4,
    parameter int BR_FLUSH_CYC = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_src1_i,
    input  logic [REG_AW-1:0] id_src2_i,
    input  logic              id_use_src1_i,
    input  logic              id_use_src2_i,
    input  logic [REG_AW-1:0] exe_dest_i,
    input  logic              exe_wb_en_i,
    input  logic              exe_mem_r_en_i,
    input  logic [REG_AW-1:0] mem_dest_i,
    input  logic              mem_wb_en_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              freeze_pc_o,
    output logic              freeze_if_id_o,
    output logic              freeze_id_ex_o,
    output logic              freeze_ex_mem_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              mem_err_o,
    output logic              mem_err_sticky_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [2:0] BR_EXTRA    = 3'(BR_FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       waitCnt_q, waitCnt_d;
    logic [2:0]       brRemain_q, brRemain_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
    logic             errSticky_q, errSticky_d;

    logic hitSrc1, hitSrc2, rawHit, memStall;
    logic freezeAll, freezeFront, flushBoth, bubble, memErr;
    logic countStall, countFlush;

`ifdef HAZARD_FWD_EN
    // With forwarding only a load in EXE can't supply its result in time.
    assign hitSrc1 = exe_wb_en_i & exe_mem_r_en_i & (exe_dest_i == id_src1_i);
    assign hitSrc2 = exe_wb_en_i & exe_mem_r_en_i & (exe_dest_i == id_src2_i);

    // The MEM-stage producer is always forwarded, so its fields are not needed.
    logic [REG_AW:0] unusedMemFields;
    assign unusedMemFields = {mem_wb_en_i, mem_dest_i};
`else
    // Without forwarding any pending writer in EXE or MEM blocks the reader.
    assign hitSrc1 = (exe_wb_en_i & (exe_dest_i == id_src1_i)) |
                     (mem_wb_en_i & (mem_dest_i == id_src1_i));
    assign hitSrc2 = (exe_wb_en_i & (exe_dest_i == id_src2_i)) |
                     (mem_wb_en_i & (mem_dest_i == id_src2_i));

    // Load-ness of the EXE producer only matters when forwarding exists.
    logic unusedLoadFlag;
    assign unusedLoadFlag = exe_mem_r_en_i;
`endif

    assign rawHit   = id_valid_i & ((id_use_src1_i & hitSrc1) | (id_use_src2_i & hitSrc2));
    assign memStall = mem_req_i & ~mem_ready_i;

    // Next-state and same-cycle control decode; memory stall beats branch beats RAW.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        brRemain_d  = brRemain_q;
        freezeAll   = 1'b0;
        freezeFront = 1'b0;
        flushBoth   = 1'b0;
        bubble      = 1'b0;
        memErr      = 1'b0;
        countStall  = 1'b0;
        countFlush  = 1'b0;
        case (state_q)
            RUN: begin
                if (memStall) begin
                    freezeAll = 1'b1;
                    state_d   = MEM_WAIT;
                    waitCnt_d = 8'd1;
                end else if (branch_taken_i) begin
                    flushBoth  = 1'b1;
                    countFlush = 1'b1;
                    if (BR_FLUSH_CYC > 1) begin
                        state_d    = BR_FLUSH;
                        brRemain_d = BR_EXTRA;
                    end
                end else if (rawHit) begin
                    freezeFront = 1'b1;
                    bubble      = 1'b1;
                    countStall  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d   = RUN;
                    waitCnt_d = 8'd0;
                    if (branch_taken_i) begin
                        flushBoth  = 1'b1;
                        countFlush = 1'b1;
                        if (BR_FLUSH_CYC > 1) begin
                            state_d    = BR_FLUSH;
                            brRemain_d = BR_EXTRA;
                        end
                    end
                end else if (waitCnt_q < TIMEOUT_LIM) begin
                    freezeAll = 1'b1;
                    waitCnt_d = waitCnt_q + 8'd1;
                end else begin
                    memErr    = 1'b1;
                    state_d   = RUN;
                    waitCnt_d = 8'd0;
                end
            end
            BR_FLUSH: begin
                if (memStall) begin
                    freezeAll  = 1'b1;
                    state_d    = MEM_WAIT;
                    waitCnt_d  = 8'd1;
                    brRemain_d = 3'd0;
                end else begin
                    flushBoth  = 1'b1;
                    brRemain_d = brRemain_q - 3'd1;
                    if (brRemain_q <= 3'd1) begin
                        state_d    = RUN;
                        brRemain_d = 3'd0;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating event counters and the sticky timeout flag.
    always_comb begin
        stallCnt_d  = stallCnt_q;
        flushCnt_d  = flushCnt_q;
        errSticky_d = errSticky_q | memErr;
        if (countStall && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
        if (countFlush && (flushCnt_q != CNT_MAX)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end
    end

    // State, counters and sticky flag, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            waitCnt_q   <= 8'd0;
            brRemain_q  <= 3'd0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
            errSticky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            brRemain_q  <= brRemain_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
            errSticky_q <= errSticky_d;
        end
    end

    // Strobes are gated by rst so every freeze/flush drops the moment reset rises.
    assign freeze_pc_o      = ~rst & (freezeAll | freezeFront);
    assign freeze_if_id_o   = ~rst & (freezeAll | freezeFront);
    assign freeze_id_ex_o   = ~rst & freezeAll;
    assign freeze_ex_mem_o  = ~rst & freezeAll;
    assign flush_if_id_o    = ~rst & flushBoth;
    assign flush_id_ex_o    = ~rst & (flushBoth | bubble);
    assign mem_err_o        = ~rst & memErr;
    assign mem_err_sticky_o = errSticky_q;
    assign stall_cnt_o      = stallCnt_q;
    assign flush_cnt_o      = flushCnt_q;

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central pipeline control for the 5-stage ARM core.
- Generates freeze/flush for the PC, IF/ID, ID/EX (ID_Stage_Reg) and EX/MEM registers from three sources: RAW data hazards, taken branches, and a multi-cycle memory wait handshake.
- Holds a small FSM for memory wait and multi-cycle branch flush, plus saturating event counters for performance debug.

Parameters:
- REG_AW, 4, register-address width.
- BR_FLUSH_CYC, 1, cycles flush_if_id/flush_id_ex are held per taken branch (1..7).
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before forced release (2..255).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  instruction in ID is valid
- id_src1  in  REG_AW  Rn address in ID
- id_src2  in  REG_AW  Rm/Rd address in ID
- id_use_src1  in  1  ID instruction reads src1
- id_use_src2  in  1  ID instruction reads src2
- exe_dest  in  REG_AW  dest held in ID/EX register
- exe_wb_en  in  1  ID/EX WB_EN
- exe_mem_r_en  in  1  ID/EX MEM_R_EN (load)
- mem_dest  in  REG_AW  dest held in EX/MEM register
- mem_wb_en  in  1  EX/MEM WB_EN
- branch_taken  in  1  taken branch resolved in EXE
- mem_req  in  1  MEM stage has a load/store active
- mem_ready  in  1  memory completes this cycle
- freeze_pc  out  1
- freeze_if_id  out  1
- freeze_id_ex  out  1  drives ID_Stage_Reg freeze
- freeze_ex_mem  out  1
- flush_if_id  out  1
- flush_id_ex  out  1  drives ID_Stage_Reg flush
- mem_err  out  1  one-cycle pulse on timeout
- mem_err_sticky  out  1  set on timeout, cleared by rst only
- stall_cnt  out  CNT_W  RAW stall cycles, saturating
- flush_cnt  out  CNT_W  branch events, saturating

Behaviour:
- States: RUN, MEM_WAIT, BR_FLUSH. Reset: state=RUN, all outputs 0, counters 0.
- rst asserted in any state forces RUN immediately; all freezes/flushes drop asynchronously.
- raw_hit (combinational): id_valid & ((id_use_src1 & hit(id_src1)) | (id_use_src2 & hit(id_src2))).
  - hit(r) = (exe_wb_en & exe_dest==r) | (mem_wb_en & mem_dest==r).
- mem_stall = mem_req & ~mem_ready.
- Priority within a cycle: mem_stall > branch_taken > raw_hit.
- RUN, mem_stall:
  - freeze_pc, freeze_if_id, freeze_id_ex and freeze_ex_mem are all 1 in the same cycle.
  - Next state MEM_WAIT; wait counter = 1.
- RUN, branch_taken (no mem_stall):
  - flush_if_id=flush_id_ex=1 the same cycle; flush_cnt+1.
  - If BR_FLUSH_CYC>1, go to BR_FLUSH with remaining count BR_FLUSH_CYC-1.
- RUN, raw_hit only:
  - freeze_pc=freeze_if_id=1 and flush_id_ex=1 (bubble), all combinational; stall_cnt+1.
  - freeze_id_ex=0.
- MEM_WAIT:
  - mem_ready=0 and counter<MEM_TIMEOUT: all four freezes held, counter+1.
  - mem_ready=1: freezes 0 this cycle, next state RUN. A simultaneous branch_taken is handled this cycle as in RUN.
  - counter==MEM_TIMEOUT with mem_ready=0: freezes 0, mem_err=1 for one cycle, mem_err_sticky set, next state RUN.
  - raw_hit and branch_taken do not affect outputs while frozen.
- BR_FLUSH: flush_if_id=flush_id_ex=1 while remaining>0, decrementing each cycle; at 0 go to RUN.
  - mem_stall arriving in BR_FLUSH takes priority: freezes assert, flushes drop, remaining count discarded, next state MEM_WAIT.
- Counters saturate at 2^CNT_W-1 with no wrap.
- Register 0 is not special: a match on r0 still stalls (ARM r0 is general purpose).

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: an EXE/MEM forwarding unit exists, so hit(r) = exe_wb_en & exe_mem_r_en & exe_dest==r. Only load-use hazards stall, for exactly 1 cycle.
- Undefined: full hit() as above, with stalls until the producer leaves MEM.
- Ports and all other behaviour are identical in both builds.

Test Plan:
- Reset mid-MEM_WAIT (counter=5) -> all freezes 0 at once; state RUN; counters 0.
- id_valid=1, id_src1=3, id_use_src1=1, exe_wb_en=1, exe_dest=3, exe_mem_r_en=0 -> freeze_pc=freeze_if_id=flush_id_ex=1, stall_cnt=1. With HAZARD_FWD_EN: no stall; with exe_mem_r_en=1: stall exactly 1 cycle.
- mem_req=1, mem_ready=0 for 4 cycles then 1 -> four freezes high for cycles 0..3, low in cycle 4; mem_err stays 0.
- mem_req=1, mem_ready held 0 with MEM_TIMEOUT=16 -> freezes high 16 cycles, drop at the timeout cycle; mem_err pulses once; mem_err_sticky=1 until rst.
- BR_FLUSH_CYC=3, branch_taken one cycle alongside raw_hit -> flushes high 3 consecutive cycles; flush_cnt=1, stall_cnt=0. branch_taken coincident with mem_stall -> freezes only, no flush.
- Force 2^CNT_W+5 RAW stall cycles -> stall_cnt stays at all-ones.
